// File: rtl/mm_gen.sv
// ---------------------------------------------------------------------------
// mm_gen : restartable NxN signed matrix-multiply engine on a shared
//          request/response memory port.
//
// On start the engine reads A (N*N words at ADRA) and B (N*N words at ADRB)
// into local buffers, computes C = A*B one element at a time with an N-cycle
// signed MAC loop, and writes each C element to ADRO as soon as it is ready.
// After the last write is accepted it pulses done and returns to idle.
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst       asynchronous reset, active low
//   start     job start, only looked at while idle
//   cfg_trb   1 = B is stored transposed in memory (latched on start)
//   cfg_sat   1 = clamp C to the signed DW range, 0 = keep low DW bits
//   in_val    read data valid (responses return in request order)
//   in_dat    read data
//   in_ouval  current request accepted this cycle
//   ou_val    request valid
//   ou_adr    request byte address
//   ou_dat    write data
//   ou_wrt    1 = write request, 0 = read request
//   busy      job in progress
//   done      one-cycle pulse after the final write is accepted
// ---------------------------------------------------------------------------
module mm_gen #(
  parameter int          N    = 4,
  parameter int          DW   = 32,
  parameter logic [31:0] ADRA = 32'h3800_00C0,
  parameter logic [31:0] ADRB = 32'h3800_0100,
  parameter logic [31:0] ADRO = 32'h3800_0140
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cfg_trb,
  input  logic          cfg_sat,
  input  logic          in_val,
  input  logic [DW-1:0] in_dat,
  input  logic          in_ouval,
  output logic          ou_val,
  output logic [31:0]   ou_adr,
  output logic [DW-1:0] ou_dat,
  output logic          ou_wrt,
  output logic          busy,
  output logic          done
);

  localparam int NN  = N * N;
  localparam int TOT = 2 * NN;
  localparam int CW  = $clog2(TOT + 1);
  localparam int XW  = $clog2(NN);
  localparam int IW  = $clog2(N);
  localparam int AW  = 2 * DW + 3;

  localparam logic [CW-1:0] TOT_C  = CW'(TOT);
  localparam logic [CW-1:0] NN_C   = CW'(NN);
  localparam logic [XW-1:0] NX     = XW'(N);
  localparam logic [IW-1:0] LAST_I = IW'(N - 1);

  // Signed DW-bit range limits expressed at accumulator width
  localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    STORE,
    FIN
  } state_t;

  state_t                 state;
  logic                   trb_q;
  logic                   sat_q;
  logic [CW-1:0]          req_cnt;
  logic [CW-1:0]          rsp_cnt;
  logic [IW-1:0]          row_i;
  logic [IW-1:0]          col_j;
  logic [IW-1:0]          k_idx;
  logic signed [AW-1:0]   acc;

  logic signed [DW-1:0]   abuf [NN];
  logic signed [DW-1:0]   bbuf [NN];

  logic [XW-1:0]          a_idx;
  logic [XW-1:0]          b_idx;
  logic signed [DW-1:0]   a_cur;
  logic signed [DW-1:0]   b_cur;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc_next;

  // Byte address of the n-th read: first all of A, then all of B
  function automatic logic [31:0] rd_addr(input logic [CW-1:0] n);
    if (n < NN_C)
      return ADRA + (32'(n) << 2);
    else
      return ADRB + (32'(n - NN_C) << 2);
  endfunction

  // Byte address of output element (i,j), row-major
  function automatic logic [31:0] wr_addr(input logic [IW-1:0] i,
                                          input logic [IW-1:0] j);
    return ADRO + ((32'(i) * 32'(N) + 32'(j)) << 2);
  endfunction

  // Reduce the wide accumulator to a bus word, clamping when requested
  function automatic logic [DW-1:0] fmt(input logic signed [AW-1:0] v,
                                        input logic               s);
    if (s && (v > SMAX))
      return SMAX[DW-1:0];
    else if (s && (v < SMIN))
      return SMIN[DW-1:0];
    else
      return v[DW-1:0];
  endfunction

  // One MAC term per CALC cycle. The B operand index depends on whether B
  // sits in memory as B or as its transpose; the accumulator is widened
  // enough that N products of two DW-bit values can never overflow it.
  always_comb begin
    a_idx    = XW'(row_i) * NX + XW'(k_idx);
    b_idx    = trb_q ? (XW'(col_j) * NX + XW'(k_idx))
                     : (XW'(k_idx) * NX + XW'(col_j));
    a_cur    = abuf[a_idx];
    b_cur    = bbuf[b_idx];
    prod     = a_cur * b_cur;
    acc_next = acc + {{3{prod[2*DW-1]}}, prod};
  end

  // Operand buffers. Each accepted response goes to the next free slot;
  // responses beyond the expected count or outside LOAD are dropped. The
  // buffers carry no reset because every slot is rewritten before use.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && in_val && (rsp_cnt < TOT_C)) begin
      if (rsp_cnt < NN_C)
        abuf[XW'(rsp_cnt)] <= in_dat;
      else
        bbuf[XW'(rsp_cnt - NN_C)] <= in_dat;
    end
  end

  // Main controller. All bus outputs are registered here, so the request
  // for the next address or the next write is prepared one edge ahead and
  // the address/data are zeroed whenever no request is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      trb_q   <= 1'b0;
      sat_q   <= 1'b0;
      req_cnt <= '0;
      rsp_cnt <= '0;
      row_i   <= '0;
      col_j   <= '0;
      k_idx   <= '0;
      acc     <= '0;
      ou_val  <= 1'b0;
      ou_adr  <= '0;
      ou_dat  <= '0;
      ou_wrt  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= LOAD;
            trb_q   <= cfg_trb;
            sat_q   <= cfg_sat;
            req_cnt <= '0;
            rsp_cnt <= '0;
            busy    <= 1'b1;
            ou_val  <= 1'b1;
            ou_wrt  <= 1'b0;
            ou_adr  <= rd_addr('0);
            ou_dat  <= '0;
          end
        end

        LOAD: begin
          // Requests and responses are tracked independently since reads
          // can return with any latency, including in the accept cycle.
          if (ou_val && in_ouval) begin
            req_cnt <= req_cnt + CW'(1);
            if (req_cnt == TOT_C - CW'(1)) begin
              ou_val <= 1'b0;
              ou_adr <= '0;
            end else begin
              ou_adr <= rd_addr(req_cnt + CW'(1));
            end
          end
          if (in_val && (rsp_cnt < TOT_C))
            rsp_cnt <= rsp_cnt + CW'(1);
          if (rsp_cnt == TOT_C) begin
            state <= CALC;
            row_i <= '0;
            col_j <= '0;
            k_idx <= '0;
            acc   <= '0;
          end
        end

        CALC: begin
          acc <= acc_next;
          if (k_idx == LAST_I) begin
            state  <= STORE;
            ou_val <= 1'b1;
            ou_wrt <= 1'b1;
            ou_adr <= wr_addr(row_i, col_j);
            ou_dat <= fmt(acc_next, sat_q);
          end else begin
            k_idx <= k_idx + IW'(1);
          end
        end

        STORE: begin
          // Address and data stay put until the write is taken
          if (in_ouval) begin
            ou_val <= 1'b0;
            ou_wrt <= 1'b0;
            ou_adr <= '0;
            ou_dat <= '0;
            if ((row_i == LAST_I) && (col_j == LAST_I)) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= CALC;
              k_idx <= '0;
              acc   <= '0;
              if (col_j == LAST_I) begin
                col_j <= '0;
                row_i <= row_i + IW'(1);
              end else begin
                col_j <= col_j + IW'(1);
              end
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          ou_val <= 1'b0;
          ou_wrt <= 1'b0;
          ou_adr <= '0;
          ou_dat <= '0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_gen.sv
// ---------------------------------------------------------------------------
// tb_mm_gen : directed self-checking bench for mm_gen.
//
// dut  : default N=4, DW=32 engine on a zero-latency memory model with an
//        optional random accept-stall generator.
// dut2 : N=2, DW=16 engine on a memory model with three cycles of read
//        latency and an accept on every cycle.
// ---------------------------------------------------------------------------
module tb_mm_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Signals for the N=4 / DW=32 instance
  logic        rst;
  logic        start;
  logic        cfg_trb;
  logic        cfg_sat;
  logic        in_val;
  logic [31:0] in_dat;
  logic        in_ouval = 1'b1;
  logic        ou_val;
  logic [31:0] ou_adr;
  logic [31:0] ou_dat;
  logic        ou_wrt;
  logic        busy;
  logic        done;

  // Signals for the N=2 / DW=16 instance
  logic        start2;
  logic        cfg_trb2 = 1'b0;
  logic        cfg_sat2 = 1'b0;
  logic        in_val2;
  logic [15:0] in_dat2;
  logic        in_ouval2 = 1'b1;
  logic        ou_val2;
  logic [31:0] ou_adr2;
  logic [15:0] ou_dat2;
  logic        ou_wrt2;
  logic        busy2;
  logic        done2;

  mm_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_trb  (cfg_trb),
    .cfg_sat  (cfg_sat),
    .in_val   (in_val),
    .in_dat   (in_dat),
    .in_ouval (in_ouval),
    .ou_val   (ou_val),
    .ou_adr   (ou_adr),
    .ou_dat   (ou_dat),
    .ou_wrt   (ou_wrt),
    .busy     (busy),
    .done     (done)
  );

  mm_gen #(.N(2), .DW(16)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .cfg_trb  (cfg_trb2),
    .cfg_sat  (cfg_sat2),
    .in_val   (in_val2),
    .in_dat   (in_dat2),
    .in_ouval (in_ouval2),
    .ou_val   (ou_val2),
    .ou_adr   (ou_adr2),
    .ou_dat   (ou_dat2),
    .ou_wrt   (ou_wrt2),
    .busy     (busy2),
    .done     (done2)
  );

  int checks   = 0;
  int failures = 0;

  // Every comparison in the bench goes through here
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Word memories: A at words 0.., B at words 16.. (0x100 - 0xC0 = 0x40)
  logic [31:0] mem  [0:31];
  logic [15:0] mem2 [0:31];

  function automatic logic [4:0] word_idx(input logic [31:0] adr);
    logic [31:0] off;
    off = adr - 32'h3800_00C0;
    return off[6:2];
  endfunction

  // Zero-latency read response for dut
  assign in_val = ou_val && !ou_wrt && in_ouval;
  assign in_dat = in_val ? mem[word_idx(ou_adr)] : 32'h0;

  // Accept-stall generator: 0..5 refused cycles, then one accept
  logic stall_en   = 1'b0;
  int   stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (stall_en && (stall_left > 0)) begin
      in_ouval   = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      in_ouval = 1'b1;
      if (stall_en)
        stall_left = $urandom_range(0, 5);
    end
  end

  // dut bus monitor: records writes, counts reads, checks that a refused
  // request is held unchanged and that the bus is zero when idle
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];
  int          rd_cnt   = 0;
  logic        pend     = 1'b0;
  logic [31:0] pend_adr = 32'h0;
  logic [31:0] pend_dat = 32'h0;
  always @(negedge clk) begin
    if (pend) begin
      checkOutput("hold_val", 32'(ou_val), 32'd1);
      checkOutput("hold_adr", ou_adr, pend_adr);
      checkOutput("hold_dat", ou_dat, pend_dat);
    end
    if (!ou_val)
      checkOutput("idle_bus", ou_adr | ou_dat, 32'h0);
    if (ou_val && in_ouval) begin
      if (ou_wrt) begin
        wr_adr_q.push_back(ou_adr);
        wr_dat_q.push_back(ou_dat);
      end else begin
        rd_cnt++;
      end
    end
    pend     = rst && ou_val && !in_ouval;
    pend_adr = ou_adr;
    pend_dat = ou_dat;
  end

  // dut2 monitor and three-stage read-latency pipeline
  logic [31:0] wr2_adr_q[$];
  logic [15:0] wr2_dat_q[$];
  int          rd2_cnt = 0;
  logic        rd2_req = 1'b0;
  logic [15:0] rd2_dat = 16'h0;
  logic [2:0]  pv      = 3'b000;
  logic [15:0] pd0 = 16'h0, pd1 = 16'h0, pd2 = 16'h0;
  always @(negedge clk) begin
    rd2_req = ou_val2 && !ou_wrt2 && in_ouval2;
    rd2_dat = mem2[word_idx(ou_adr2)];
    if (rd2_req)
      rd2_cnt++;
    if (ou_val2 && ou_wrt2 && in_ouval2) begin
      wr2_adr_q.push_back(ou_adr2);
      wr2_dat_q.push_back(ou_dat2);
    end
  end
  always @(posedge clk) begin
    pv  <= {pv[1:0], rd2_req};
    pd0 <= rd2_dat;
    pd1 <= pd0;
    pd2 <= pd1;
  end
  assign in_val2 = pv[2];
  assign in_dat2 = pv[2] ? pd2 : 16'h0;

  logic [31:0] c_exp  [0:15];
  logic [15:0] c2_exp [0:3];

  // Run one dut job: pulse start (plus an optional stray start at cycle
  // 'glitch'), count cycles until done, then confirm done is one cycle long
  task automatic applyStimulus(input logic trb, input logic sat,
                               input int glitch, output int cyc);
    @(negedge clk);
    wr_adr_q.delete();
    wr_dat_q.delete();
    rd_cnt  = 0;
    cfg_trb = trb;
    cfg_sat = sat;
    start   = 1'b1;
    cyc     = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (glitch > 0) && (cyc == glitch);
      if (cyc == 1)
        checkOutput("busy_rise", 32'(busy), 32'd1);
    end while (!done && (cyc < 5000));
    checkOutput("done_seen", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
  endtask

  // Compare the recorded writes of the last dut job against c_exp
  task automatic checkWrites(input string tag);
    checkOutput({tag, "_wcount"}, 32'(wr_dat_q.size()), 32'd16);
    checkOutput({tag, "_reads"}, 32'(rd_cnt), 32'd32);
    for (int m = 0; (m < 16) && (m < wr_dat_q.size()); m++) begin
      checkOutput({tag, "_adr"}, wr_adr_q[m], 32'h3800_0140 + 32'(m * 4));
      checkOutput({tag, "_dat"}, wr_dat_q[m], c_exp[m]);
    end
  endtask

  // Run one dut2 job starting on the current cycle
  task automatic runJob2(input string tag);
    int cyc;
    wr2_adr_q.delete();
    wr2_dat_q.delete();
    rd2_cnt = 0;
    start2  = 1'b1;
    cyc     = 0;
    do begin
      @(negedge clk);
      cyc++;
      start2 = 1'b0;
      if (cyc == 1)
        checkOutput({tag, "_busy"}, 32'(busy2), 32'd1);
    end while (!done2 && (cyc < 2000));
    checkOutput({tag, "_done_seen"}, 32'(done2), 32'd1);
    checkOutput({tag, "_reads"}, 32'(rd2_cnt), 32'd8);
    checkOutput({tag, "_wcount"}, 32'(wr2_dat_q.size()), 32'd4);
    for (int m = 0; (m < 4) && (m < wr2_dat_q.size()); m++) begin
      checkOutput({tag, "_adr"}, wr2_adr_q[m], 32'h3800_0140 + 32'(m * 4));
      checkOutput({tag, "_dat"}, 32'(wr2_dat_q[m]), 32'(c2_exp[m]));
    end
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done2), 32'd0);
  endtask

  initial begin
    int cyc;
    int s;

    rst     = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    cfg_trb = 1'b0;
    cfg_sat = 1'b0;
    for (int m = 0; m < 32; m++) begin
      mem[m]  = 32'h0;
      mem2[m] = 16'h0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_val",   32'(ou_val), 32'd0);
    checkOutput("rst_wrt",   32'(ou_wrt), 32'd0);
    checkOutput("rst_adr",   ou_adr, 32'h0);
    checkOutput("rst_dat",   ou_dat, 32'h0);
    checkOutput("rst_busy",  32'(busy), 32'd0);
    checkOutput("rst_done",  32'(done), 32'd0);
    checkOutput("rst_busy2", 32'(busy2), 32'd0);
    rst = 1'b1;
    $display("[TB] reset released");

    // A = identity, B[m] = m+1 -> C = B, full-rate bus
    for (int m = 0; m < 16; m++) begin
      mem[m]      = ((m / 4) == (m % 4)) ? 32'd1 : 32'd0;
      mem[16 + m] = 32'(m + 1);
      c_exp[m]    = 32'(m + 1);
    end
    applyStimulus(1'b0, 1'b0, 0, cyc);
    checkOutput("t1_latency", 32'(cyc), 32'd114);
    checkWrites("t1");

    // A all 2, B all -3 -> every C = -24, with random accept stalls
    for (int m = 0; m < 16; m++) begin
      mem[m]      = 32'd2;
      mem[16 + m] = 32'hFFFF_FFFD;
      c_exp[m]    = 32'hFFFF_FFE8;
    end
    stall_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, cyc);
    stall_en = 1'b0;
    checkWrites("t2");

    // Max positive operands: saturated and wrapped results
    for (int m = 0; m < 32; m++)
      mem[m] = 32'h7FFF_FFFF;
    for (int m = 0; m < 16; m++)
      c_exp[m] = 32'h7FFF_FFFF;
    applyStimulus(1'b0, 1'b1, 0, cyc);
    checkWrites("t3sat");
    for (int m = 0; m < 16; m++)
      c_exp[m] = 32'h0000_0004;
    applyStimulus(1'b0, 1'b0, 0, cyc);
    checkWrites("t3wrap");

    // A[i][k] = i-k, B[k][j] = 4k+j+1; plain and transposed B layouts
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        mem[i * 4 + j]      = 32'(i - j);
        mem[16 + i * 4 + j] = 32'(4 * i + j + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s = s + (i - k) * (4 * k + j + 1);
        c_exp[i * 4 + j] = 32'(s);
      end
    end
    applyStimulus(1'b0, 1'b0, 0, cyc);
    checkWrites("t4plain");
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        mem[16 + j * 4 + k] = 32'(4 * k + j + 1);
    applyStimulus(1'b1, 1'b0, 0, cyc);
    checkWrites("t4trans");

    // Reset during the fifth STORE aborts the job
    for (int m = 0; m < 16; m++) begin
      mem[m]      = ((m / 4) == (m % 4)) ? 32'd1 : 32'd0;
      mem[16 + m] = 32'(m + 1);
      c_exp[m]    = 32'(m + 1);
    end
    @(negedge clk);
    wr_adr_q.delete();
    wr_dat_q.delete();
    cfg_trb = 1'b0;
    cfg_sat = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!(ou_val && ou_wrt && (wr_dat_q.size() == 4)) && (cyc < 1000)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("t5_store5_found", 32'(ou_val && ou_wrt), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("t5_val_async", 32'(ou_val), 32'd0);
    @(negedge clk);
    checkOutput("t5_val",  32'(ou_val), 32'd0);
    checkOutput("t5_wrt",  32'(ou_wrt), 32'd0);
    checkOutput("t5_adr",  ou_adr, 32'h0);
    checkOutput("t5_dat",  ou_dat, 32'h0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t5_no_more_writes", 32'(wr_dat_q.size()), 32'd4);
    checkOutput("t5_idle_busy", 32'(busy), 32'd0);
    // Second job after release, with a stray start pulse while busy
    applyStimulus(1'b0, 1'b0, 20, cyc);
    checkOutput("t5_latency", 32'(cyc), 32'd114);
    checkWrites("t5");

    // N=2, DW=16 with read latency 3, then an immediate restart
    mem2[0]  = 16'hFFFF;
    mem2[1]  = 16'd2;
    mem2[2]  = 16'd3;
    mem2[3]  = 16'hFFFC;
    mem2[16] = 16'd5;
    mem2[17] = 16'hFFFA;
    mem2[18] = 16'd7;
    mem2[19] = 16'd8;
    c2_exp[0] = 16'd9;
    c2_exp[1] = 16'd22;
    c2_exp[2] = 16'hFFF3;
    c2_exp[3] = 16'hFFCE;
    @(negedge clk);
    runJob2("t6a");
    runJob2("t6b");

    $display("[TB] all directed steps complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_gen.md
Name: mm_gen

Overview:
- Parametrised, restartable successor to the fixed 4x4 matrix-multiply engine on the user-project memory bus.
- On `start`, fetches A (NxN) and B (NxN) over the shared request/response port and computes C = A*B with signed MACs.
- Writes C back one word per element, then pulses `done` and returns to idle, ready for another job.
- Adds transposed-B and saturating-output modes.

Parameters:
- N, 4, matrix dimension; legal 2..8.
- DW, 32, element/bus data width; legal 8..32.
- ADRA, 32'h3800_00C0, byte base of A (row-major, 4-byte stride).
- ADRB, 32'h3800_0100, byte base of B.
- ADRO, 32'h3800_0140, byte base of C output.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- start  in  1  job start; sampled in IDLE only.
- cfg_trb  in  1  1 = B stored transposed (B[k][j] at ADRB+4*(j*N+k)); latched on start.
- cfg_sat  in  1  1 = saturate C to signed DW range, 0 = wrap (low DW bits); latched on start.
- in_val  in  1  read data valid.
- in_dat  in  DW  read data.
- in_ouval  in  1  request accepted this cycle.
- ou_val  out  1  request valid.
- ou_adr  out  32  request byte address.
- ou_dat  out  DW  write data.
- ou_wrt  out  1  1 = write request, 0 = read.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last write is accepted.

Behaviour:
- Reset: state IDLE; all outputs 0; counters, accumulator and config latches cleared. Reset mid-job aborts immediately; no partial writes are issued afterwards.
- States: IDLE -> LOAD -> CALC -> STORE -> (CALC | FIN) -> IDLE.
- IDLE:
  - `start`=1 latches cfg_*, moves to LOAD, `busy`=1 next cycle.
  - `start` while not IDLE is ignored.
- LOAD:
  - Issue 2*N*N reads: A words in order ADRA+4*m for m=0..N*N-1, then B words ADRB+4*m.
  - `ou_val`=1 and `ou_wrt`=0 while requests remain.
  - A request retires on the cycle `ou_val`&`in_ouval`; the address advances next cycle.
  - Responses arrive in request order with any latency ≥0, possibly in the same cycle as acceptance.
  - Each `in_val` stores `in_dat` into the next buffer slot; `in_val` beyond 2*N*N expected words is ignored.
  - `ou_val` drops once all requests have been accepted.
  - LOAD -> CALC on the cycle after the last response is received.
- CALC:
  - Element (i,j) in row-major order; accumulator cleared at entry.
  - Exactly N cycles, k=0..N-1: acc += A[i][k]*B[k][j], signed DW x DW.
  - Accumulator width is 2*DW+3 bits; it cannot overflow.
  - Then -> STORE.
- STORE:
  - `ou_val`=1, `ou_wrt`=1, `ou_adr`=ADRO+4*(i*N+j).
  - `ou_dat` = sat ? clamp(acc, -2^(DW-1), 2^(DW-1)-1) : acc[DW-1:0], sign-extended to DW.
  - `ou_dat` and `ou_adr` are held stable until `in_ouval`.
  - On accept: if (i,j)=(N-1,N-1) -> FIN, else advance j (wrap to 0 and increment i) and return to CALC.
- FIN: `done`=1 for exactly one cycle, `busy`=0 the same cycle, -> IDLE.
- Timing with `in_ouval` tied 1 and zero read latency:
  - LOAD takes 2*N*N+1 cycles.
  - Each element takes N+1 cycles.
  - `done` rises 2*N*N+1 + N*N*(N+1) + 1 cycles after `start`.
  - For N=4: 114 cycles.
- `ou_val` is never asserted in IDLE, CALC or FIN.
- `ou_adr` and `ou_dat` are 0 whenever `ou_val`=0.

Test Plan:
- N=4, A=I, B[m]=m+1, cfg=00, `in_ouval`=1, zero latency -> 16 writes of 1..16 at 0x3800_0140..0x3800_017C in order; `done` at cycle 114 after start.
- A all 2, B all -3, N=4 -> every C = -24 (0xFFFF_FFE8); random 0..5-cycle `in_ouval` stalls -> identical data, addresses held during stalls, one write per element.
- A all 0x7FFF_FFFF, B all 0x7FFF_FFFF: cfg_sat=1 -> all C = 0x7FFF_FFFF; cfg_sat=0 -> all C = 0x0000_0004.
- cfg_trb=1 with B memory holding B^T -> output matches the cfg_trb=0 run on B.
- rst=0 during the 5th STORE -> outputs 0 next edge, no further writes; second job after release completes correctly; `start` pulsed while busy ignored.
- N=2, DW=16, read latency 3 with pipelined accepts -> 8 reads, 4 writes at ADRO+0..+12 with correct products; `done` single cycle; immediate restart accepted.
